// File: rtl/dual_port_ram_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dual_port_ram_arbiter_pkg : shared constants and helpers for the RAM arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
package dual_port_ram_arbiter_pkg;

  localparam int NUM_PORTS = 2;

  // Two accesses to the same word may share a cycle only when both are reads.
  function automatic logic pair_blocked(input logic same_address,
                                        input logic write_a,
                                        input logic write_b);
    return same_address & (write_a | write_b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dual_port_ram_arbiter_selector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// round_robin_dual_selector : picks up to two requesters in rotating order
// Revision: 1.0
// ----------------------------------------------------------------------------
module round_robin_dual_selector
  import dual_port_ram_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = 4,
  parameter int INDEX_WIDTH = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0]            valid_i,
  input  logic [REQUESTERS*REQUESTERS-1:0] conflict_i,
  input  logic [INDEX_WIDTH-1:0]           pointer_i,
  output logic [REQUESTERS-1:0]            grant_a_o,
  output logic [REQUESTERS-1:0]            grant_b_o,
  output logic [INDEX_WIDTH-1:0]           index_a_o,
  output logic [INDEX_WIDTH-1:0]           index_b_o,
  output logic                             found_a_o,
  output logic                             found_b_o
);

  // Row a holds the requesters that may not share a cycle with requester a.
  logic [REQUESTERS-1:0]  conflict_row [REQUESTERS];
  logic [INDEX_WIDTH-1:0] scan_idx;

  for (genvar a = 0; a < REQUESTERS; a++) begin : g_row
    assign conflict_row[a] = conflict_i[a*REQUESTERS +: REQUESTERS];
  end

  always_comb begin
    found_a_o = 1'b0;
    found_b_o = 1'b0;
    index_a_o = '0;
    index_b_o = '0;
    grant_a_o = '0;
    grant_b_o = '0;
    scan_idx  = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      scan_idx = INDEX_WIDTH'((int'(pointer_i) + k) % REQUESTERS);
      if (valid_i[scan_idx]) begin
        if (!found_a_o) begin
          found_a_o = 1'b1;
          index_a_o = scan_idx;
        end else if (!found_b_o && !conflict_row[index_a_o][scan_idx]) begin
          found_b_o = 1'b1;
          index_b_o = scan_idx;
        end
      end
    end
    grant_a_o[index_a_o] = found_a_o;
    grant_b_o[index_b_o] = found_b_o;
  end

endmodule
`default_nettype wire

// File: rtl/dual_port_ram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dual_port_ram_arbiter : round-robin sharing of a true dual-port RAM
// Revision: 1.0
// ----------------------------------------------------------------------------
module dual_port_ram_arbiter
  import dual_port_ram_arbiter_pkg::*;
#(
  parameter int WIDTH                 = 8,
  parameter int DEPTH                 = 16,
  parameter int REQUESTERS            = 4,
  parameter int ADDRESS_WIDTH         = $clog2(DEPTH),
  parameter int REQUESTER_INDEX_WIDTH = $clog2(REQUESTERS)
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic [REQUESTERS-1:0]               request_valid,
  output logic [REQUESTERS-1:0]               request_ready,
  input  logic [REQUESTERS-1:0]               request_write,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] request_address,
  input  logic [REQUESTERS*WIDTH-1:0]         request_write_data,
  output logic [REQUESTERS-1:0]               response_valid,
  output logic [REQUESTERS*WIDTH-1:0]         response_data,
  output logic                                port_0_access_enable,
  output logic                                port_1_access_enable,
  output logic                                port_0_write,
  output logic                                port_1_write,
  output logic [ADDRESS_WIDTH-1:0]            port_0_address,
  output logic [ADDRESS_WIDTH-1:0]            port_1_address,
  output logic [WIDTH-1:0]                    port_0_write_data,
  output logic [WIDTH-1:0]                    port_1_write_data,
  input  logic [WIDTH-1:0]                    port_0_read_data,
  input  logic [WIDTH-1:0]                    port_1_read_data
);

  localparam int IW = REQUESTER_INDEX_WIDTH;

  logic [ADDRESS_WIDTH-1:0]         req_addr [REQUESTERS];
  logic [WIDTH-1:0]                 req_data [REQUESTERS];
  logic [REQUESTERS*REQUESTERS-1:0] conflict;
  logic [REQUESTERS-1:0]            grant_a, grant_b;
  logic [IW-1:0]                    idx_a, idx_b, last_idx;
  logic                             found_a, found_b, port_0_go, port_1_go;
  logic [IW-1:0]                    pointer_d, pointer_q;
  logic [NUM_PORTS-1:0]             trk_valid_d, trk_valid_q;
  logic [IW-1:0]                    trk_idx_d [NUM_PORTS];
  logic [IW-1:0]                    trk_idx_q [NUM_PORTS];
  logic [WIDTH-1:0]                 port_rd   [NUM_PORTS];
  logic [WIDTH-1:0]                 resp_d    [REQUESTERS];
  logic [WIDTH-1:0]                 resp_q    [REQUESTERS];

  for (genvar i = 0; i < REQUESTERS; i++) begin : g_unpack
    assign req_addr[i] = request_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign req_data[i] = request_write_data[i*WIDTH +: WIDTH];
    assign response_data[i*WIDTH +: WIDTH] = resp_d[i];
  end

  for (genvar a = 0; a < REQUESTERS; a++) begin : g_conf_a
    for (genvar b = 0; b < REQUESTERS; b++) begin : g_conf_b
      assign conflict[a*REQUESTERS+b] = pair_blocked(req_addr[a] == req_addr[b],
                                                     request_write[a], request_write[b]);
    end
  end

  round_robin_dual_selector #(
    .REQUESTERS  (REQUESTERS),
    .INDEX_WIDTH (IW)
  ) u_selector (
    .valid_i    (request_valid),
    .conflict_i (conflict),
    .pointer_i  (pointer_q),
    .grant_a_o  (grant_a),
    .grant_b_o  (grant_b),
    .index_a_o  (idx_a),
    .index_b_o  (idx_b),
    .found_a_o  (found_a),
    .found_b_o  (found_b)
  );

  // Nothing is granted while reset is held, even though the selector keeps evaluating.
  assign port_0_go     = found_a & resetn;
  assign port_1_go     = found_b & resetn;
  assign request_ready = (grant_a | grant_b) & {REQUESTERS{resetn}};

  assign port_0_access_enable = port_0_go;
  assign port_0_write         = port_0_go & request_write[idx_a];
  assign port_0_address       = port_0_go ? req_addr[idx_a] : '0;
  assign port_0_write_data    = port_0_go ? req_data[idx_a] : '0;
  assign port_1_access_enable = port_1_go;
  assign port_1_write         = port_1_go & request_write[idx_b];
  assign port_1_address       = port_1_go ? req_addr[idx_b] : '0;
  assign port_1_write_data    = port_1_go ? req_data[idx_b] : '0;

  assign last_idx  = found_b ? idx_b : idx_a;
  assign pointer_d = !found_a                       ? pointer_q :
                     (last_idx == IW'(REQUESTERS-1)) ? '0 : last_idx + 1'b1;

  assign trk_valid_d[0] = port_0_go & ~request_write[idx_a];
  assign trk_valid_d[1] = port_1_go & ~request_write[idx_b];
  assign trk_idx_d[0]   = idx_a;
  assign trk_idx_d[1]   = idx_b;
  assign port_rd[0]     = port_0_read_data;
  assign port_rd[1]     = port_1_read_data;

  // Read data comes straight from the RAM in the cycle after the grant; other slices hold.
  always_comb begin
    response_valid = '0;
    resp_d         = resp_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (trk_valid_q[k]) begin
        response_valid[trk_idx_q[k]] = 1'b1;
        resp_d[trk_idx_q[k]]         = port_rd[k];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pointer_q   <= '0;
      trk_valid_q <= '0;
      for (int k = 0; k < NUM_PORTS; k++) trk_idx_q[k] <= '0;
      for (int i = 0; i < REQUESTERS; i++) resp_q[i] <= '0;
    end else begin
      pointer_q   <= pointer_d;
      trk_valid_q <= trk_valid_d;
      trk_idx_q   <= trk_idx_d;
      resp_q      <= resp_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/dual_port_ram_arbiter.md
Name: dual_port_ram_arbiter

Overview:
- Shares one synchronous true dual-port RAM (both ports on `clock`, registered read, 1-cycle read latency) between REQUESTERS independent requesters.
- Each cycle it grants up to two requests using rotating (round-robin) priority: one on RAM port 0, one on RAM port 1.
- It blocks same-address port collisions and routes each read result back to the requester that issued it.
- Sits between bus-side agents (DMA, cores) and the RAM instance.

Parameters:
- WIDTH, 8, data word width.
- DEPTH, 16, RAM depth in words.
- REQUESTERS, 4, number of requesters, >=2.
- ADDRESS_WIDTH, `CLOG2(DEPTH), address width.
- REQUESTER_INDEX_WIDTH, `CLOG2(REQUESTERS), width of the internal grant index.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- request_valid  input  REQUESTERS  per-requester request present.
- request_ready  output  REQUESTERS  per-requester grant this cycle (combinational).
- request_write  input  REQUESTERS  1 = write, 0 = read.
- request_address  input  REQUESTERS*ADDRESS_WIDTH  packed; slice i belongs to requester i.
- request_write_data  input  REQUESTERS*WIDTH  packed write data.
- response_valid  output  REQUESTERS  read data valid for requester i.
- response_data  output  REQUESTERS*WIDTH  packed read data.
- port_0_access_enable, port_1_access_enable  output  1  RAM port enable.
- port_0_write, port_1_write  output  1  RAM port write.
- port_0_address, port_1_address  output  ADDRESS_WIDTH  RAM port address.
- port_0_write_data, port_1_write_data  output  WIDTH  RAM port write data.
- port_0_read_data, port_1_read_data  input  WIDTH  RAM read data, valid 1 cycle after a read access.

Behaviour:
- Reset (resetn low, asynchronous assert, synchronous to clock on release):
  - priority pointer = 0;
  - response_valid = 0; response_data = 0;
  - response-tracking registers cleared.
  - All request_ready and RAM enables are 0 while in reset.
- Handshake:
  - A request transfers when request_valid[i] & request_ready[i] are both high.
  - request_ready[i] is combinational from the current cycle's valids and addresses.
  - A requester holds valid, write, address and data stable until granted.
- Grant selection, scanning requesters in order P, P+1, …, P+REQUESTERS-1 (mod REQUESTERS):
  - Port 0 gets the first valid requester A.
  - Port 1 gets the next valid requester B after A in scan order whose address differs from A's, or whose address is equal and both A and B are reads.
  - A requester with the same address as A where either access is a write is skipped this cycle. The scan continues past it for B.
  - With no valid requests, both enables are 0. With exactly one grantable request, only port 0 is used.
- Port drive:
  - port_k_access_enable = 1 for a granted port.
  - port_k_write, address and write_data are copied from the granted requester's slice.
  - Ungranted port: all port outputs 0.
- Pointer update, on any cycle with at least one grant:
  - P <= (index of last granted requester + 1) mod REQUESTERS, where the last granted is B if granted, else A.
  - No grant: P holds.
  - Fairness requirement: a continuously valid, non-conflicting requester is granted within ceil(REQUESTERS/2) cycles.
- Read return:
  - A granted read on port k registers (read flag, requester index) into tracker k.
  - In the next cycle, response_valid[index] = 1 and response_data slice = port_k_read_data.
  - Response is a single-cycle pulse with no backpressure; requesters must accept.
  - Both trackers may fire in the same cycle, always for different requesters.
  - Writes produce no response.
  - Non-responding slices of response_data hold their last value.
- Throughput: up to 2 accesses per cycle; read latency is grant cycle + 1.
- Reset mid-operation: in-flight read responses are dropped; no response_valid after reset release for pre-reset grants.

Decomposition:
- No shared package needed; only the `clog2.vh` macro.
- One natural sub-module: `round_robin_dual_selector`.
  - Inputs: valid vector, per-requester conflict mask relative to A, pointer.
  - Outputs: one-hot grant for A and for B, plus their indices.
- The top computes the conflict mask, muxes the RAM ports, and holds the pointer and response trackers.

Test Plan:
- Reset, then idle with request_valid=0 -> both enables 0, response_valid=0, pointer stays 0.
- Requester 1 writes 0x5A to address 3; next cycle requester 2 reads address 3 -> requester 1 granted on port 0; requester 2 granted on port 0 the following cycle; response_valid[2]=1 with data 0x5A one cycle after its grant.
- All 4 requesters valid with distinct-address reads, held for 4 cycles, P=0 -> grants {0,1}, {2,3}, {0,1}, {2,3}; each response arrives 1 cycle after its grant.
- Requesters 0 and 1 both write address 7, requester 2 reads address 9, P=0 -> cycle 1 grants 0 (port 0) and 2 (port 1), 1 skipped; P becomes 3; cycle 2 grants 1.
- Requesters 0 and 3 both read address 5, P=0 -> both granted in one cycle; response_valid[0] and response_valid[3] both 1 next cycle with identical data.
- Read granted, then resetn pulsed low before the response cycle -> response_valid stays 0 through and after reset release.
